// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the digit-serial subtractor.
// State encoding is fixed so the state register is easy to probe.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Step counter width; a single-step configuration still needs one bit.
    function automatic int cnt_width(input int nstep);
        return (nstep > 1) ? $clog2(nstep) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_fs_bit.sv
// One-bit full subtractor: D = A - B - Ci, borrow-out on Co.
// Pure combinational cell, chained once per bit of the digit.
module fs_bit (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic d_o,
    output logic co_o
);

    assign d_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (~a_i & b_i) | (~(a_i ^ b_i) & ci_i);

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial A - B - BIN, BPC bits per clock, LSB first,
// with a registered borrow between steps and valid/ready on both sides.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int NSTEP = WIDTH / BPC;
    localparam int CW    = cnt_width(NSTEP);

    state_e state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             brw_q, brw_d;
    logic             amsb_q, amsb_d;
    logic             bmsb_q, bmsb_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic [BPC-1:0]   d_bits;
    logic [BPC:0]     chain;
    logic [WIDTH-1:0] res_shift;
    logic             last;

    assign chain[0] = brw_q;

    for (genvar i = 0; i < BPC; i++) begin : g_cell
        fs_bit u_fs (
            .a_i  (a_q[i]),
            .b_i  (b_q[i]),
            .ci_i (chain[i]),
            .d_o  (d_bits[i]),
            .co_o (chain[i+1])
        );
    end

    // New digit enters from the MSB side so the LSB digit ends at bit 0.
    if (BPC == WIDTH) begin : g_full
        assign res_shift = d_bits;
    end else begin : g_part
        assign res_shift = {d_bits, res_q[WIDTH-1:BPC]};
    end

    assign last = (cnt_q == CW'(NSTEP - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        res_d  = res_q;
        diff_d = diff_q;
        cnt_d  = cnt_q;
        brw_d  = brw_q;
        amsb_d = amsb_q;
        bmsb_d = bmsb_q;
        bout_d = bout_q;
        ovf_d  = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d    = a;
                    b_d    = b;
                    brw_d  = bin;
                    cnt_d  = '0;
                    amsb_d = a[WIDTH-1];
                    bmsb_d = b[WIDTH-1];
                end
            end
            RUN: begin
                a_d   = a_q >> BPC;
                b_d   = b_q >> BPC;
                res_d = res_shift;
                brw_d = chain[BPC];
                cnt_d = cnt_q + CW'(1);
                // Outputs update only on entry to DONE, so they hold otherwise.
                if (last) begin
                    diff_d = res_shift;
                    bout_d = chain[BPC];
                    ovf_d  = (amsb_q != bmsb_q)
                          && (res_shift[WIDTH-1] != amsb_q);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            diff_q <= '0;
            cnt_q  <= '0;
            brw_q  <= 1'b0;
            amsb_q <= 1'b0;
            bmsb_q <= 1'b0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            res_q  <= res_d;
            diff_q <= diff_d;
            cnt_q  <= cnt_d;
            brw_q  <= brw_d;
            amsb_q <= amsb_d;
            bmsb_q <= bmsb_d;
            bout_q <= bout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: BPC=1 directed vectors
// and a BPC=4 instance driven with reference-model operands.
module tb_serial_subtractor;

    typedef struct packed {
        logic [7:0] d;
        logic       bo;
        logic       of;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       iv0 = 1'b0, ir0, ov0, or0 = 1'b1, bin0 = 1'b0;
    logic [7:0] a0 = '0, b0 = '0, d0;
    logic       bo0, of0;

    logic       iv4 = 1'b0, ir4, ov4, or4 = 1'b1, bin4 = 1'b0;
    logic [7:0] a4 = '0, b4 = '0, d4;
    logic       bo4, of4;
    logic       rnd_en = 1'b0;

    res_t q0[$];
    res_t q4[$];
    int   checks = 0;
    int   failures = 0;

    serial_subtractor #(.WIDTH(8), .BPC(1)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(iv0), .in_ready(ir0),
        .a(a0), .b(b0), .bin(bin0),
        .out_valid(ov0), .out_ready(or0),
        .diff(d0), .bout(bo0), .ovf(of0)
    );

    serial_subtractor #(.WIDTH(8), .BPC(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4), .bin(bin4),
        .out_valid(ov4), .out_ready(or4),
        .diff(d4), .bout(bo4), .ovf(of4)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: bound expired", nm);
    endtask

    always @(negedge clk) begin : mon0
        res_t e;
        if (!rst && ov0 && or0) begin
            if (q0.size() == 0) begin
                fail_now("dut0_unexpected_result");
            end else begin
                e = q0.pop_front();
                chk("dut0_result", {d0, bo0, of0}, e);
            end
        end
    end

    always @(negedge clk) begin : mon4
        res_t e;
        if (!rst && ov4 && or4) begin
            if (q4.size() == 0) begin
                fail_now("dut4_unexpected_result");
            end else begin
                e = q4.pop_front();
                chk("dut4_result", {d4, bo4, of4}, e);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rnd_en) or4 = 1'($urandom_range(0, 1));
    end

    // Caller sits 1 time unit after a rising edge.
    task automatic issue0(input logic [7:0] a, input logic [7:0] b,
                          input logic bi, input res_t e, input bit push);
        int n = 0;
        while (!ir0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ir0) fail_now("dut0_in_ready_wait");
        a0 = a; b0 = b; bin0 = bi; iv0 = 1'b1;
        if (push) q0.push_back(e);
        @(posedge clk); #1;
        iv0 = 1'b0;
    endtask

    task automatic drain0();
        int n = 0;
        while (q0.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (q0.size() != 0) fail_now("dut0_drain");
        @(posedge clk); #1;
    endtask

    initial begin
        res_t e;
        int   n;
        logic [7:0] ra, rb;
        logic       rbi;
        logic [8:0] full;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", ir0, 1);
        chk("rst_out_valid", ov0, 0);
        chk("rst_outputs", {d0, bo0, of0}, 0);
        chk("rst_out_valid4", ov4, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // First vector with exact latency check
        issue0(8'h05, 8'h03, 1'b0, '{8'h02, 1'b0, 1'b0}, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("latency_cyc%0d", i), ov0, (i == 8) ? 1 : 0);
        end
        @(posedge clk); #1;
        chk("after_drain_ready", ir0, 1);

        issue0(8'h00, 8'h01, 1'b0, '{8'hFF, 1'b1, 1'b0}, 1'b1);
        drain0();
        issue0(8'h10, 8'h0F, 1'b1, '{8'h00, 1'b0, 1'b0}, 1'b1);
        drain0();
        issue0(8'h80, 8'h01, 1'b0, '{8'h7F, 1'b0, 1'b1}, 1'b1);
        drain0();
        issue0(8'h7F, 8'hFF, 1'b0, '{8'h80, 1'b1, 1'b1}, 1'b1);
        drain0();
        issue0(8'h00, 8'h00, 1'b1, '{8'hFF, 1'b1, 1'b0}, 1'b1);
        drain0();

        // Backpressure in DONE with in_valid and operand churn
        or0 = 1'b0;
        issue0(8'h33, 8'h11, 1'b0, '{8'h22, 1'b0, 1'b0}, 1'b1);
        n = 0;
        while (!ov0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ov0) fail_now("bp_out_valid_wait");
        for (int i = 0; i < 5; i++) begin
            iv0 = 1'b1;
            a0 = 8'(8'hA5 + 8'(i * 17));
            b0 = 8'(8'h3C ^ 8'(i * 9));
            bin0 = 1'(i);
            @(negedge clk);
            chk("bp_diff", d0, 8'h22);
            chk("bp_flags", {bo0, of0}, 0);
            chk("bp_in_ready", ir0, 0);
            chk("bp_out_valid", ov0, 1);
            @(posedge clk); #1;
        end
        iv0 = 1'b0;
        or0 = 1'b1;
        @(posedge clk); #1;
        chk("bp_idle_ready", ir0, 1);
        chk("bp_idle_valid", ov0, 0);
        chk("bp_retain_diff", d0, 8'h22);
        chk("bp_queue_empty", q0.size(), 0);
        repeat (12) @(posedge clk);
        #1;

        // Reset on the 4th RUN cycle
        issue0(8'h05, 8'h03, 1'b0, '{8'h02, 1'b0, 1'b0}, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", ov0, 0);
        chk("midrst_in_ready", ir0, 1);
        chk("midrst_outputs", {d0, bo0, of0}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("postrst_no_valid", ov0, 0);
        end
        chk("postrst_in_ready", ir0, 1);
        chk("postrst_outputs", {d0, bo0, of0}, 0);
        @(posedge clk); #1;
        issue0(8'h05, 8'h03, 1'b0, '{8'h02, 1'b0, 1'b0}, 1'b1);
        drain0();

        // BPC=4 instance: reference model with random out_ready
        rnd_en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rbi = 1'($urandom_range(0, 1));
            full = {1'b0, ra} - {1'b0, rb} - {8'h00, rbi};
            e.d = full[7:0];
            e.bo = full[8];
            e.of = (ra[7] != rb[7]) && (full[7] != ra[7]);
            n = 0;
            while (!ir4 && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
            if (!ir4) fail_now("dut4_in_ready_wait");
            a4 = ra; b4 = rb; bin4 = rbi; iv4 = 1'b1;
            q4.push_back(e);
            @(posedge clk); #1;
            iv4 = 1'b0;
            a4 = 8'($urandom);
            b4 = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        rnd_en = 1'b0;
        or4 = 1'b1;
        n = 0;
        while (q4.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (q4.size() != 0) fail_now("dut4_drain");
        repeat (4) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Parametrised digit-serial subtractor that computes DIFF = A - B - BIN over WIDTH bits.
- Processes BPC bits per clock, LSB first, with a registered borrow chain between steps.
- Successor to the single-bit full-subtractor cell, which it instantiates once per bit of the digit.
- Sits on datapaths that trade latency for area; valid/ready handshake on both input and output.

Parameters:
- WIDTH, 8: operand and result width in bits; must be at least 2.
- BPC, 1: bits processed per clock; must divide WIDTH. NSTEP = WIDTH/BPC.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  minuend, sampled on accept.
- b  input  WIDTH  subtrahend, sampled on accept.
- bin  input  1  borrow-in, sampled on accept.
- out_valid  output  1  result available; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  A - B - BIN, modulo 2^WIDTH.
- bout  output  1  borrow-out; 1 when unsigned A < B + BIN.
- ovf  output  1  two's-complement overflow.

Behaviour:
- Reset (asynchronous, active-high): state IDLE; out_valid=0, diff=0, bout=0, ovf=0; counter=0; borrow register=0. in_ready=1 while reset is released.
- FSM states: IDLE, RUN, DONE. in_ready = (state==IDLE). out_valid = (state==DONE). Both are decoded from registered state, with no combinational path from inputs.
- IDLE:
  - On in_valid&&in_ready: load shift registers with a and b, load the borrow register with bin, set counter to 0, latch a[WIDTH-1] and b[WIDTH-1] for ovf, then go to RUN.
  - Otherwise stay in IDLE.
- RUN, each cycle:
  - The chained fs_bit cells take the low BPC bits of the a/b shift registers and the borrow register.
  - The BPC result bits shift into the result register from the MSB side.
  - The a/b shift registers shift right by BPC.
  - The borrow register takes the last cell's borrow-out.
  - The counter increments.
  - When counter==NSTEP-1, the next state is DONE.
- Latency: accepted at edge k, out_valid=1 in the cycle after edge k+NSTEP (BPC=1, WIDTH=8: 8 cycles).
- DONE:
  - diff holds the result register. bout holds the final borrow.
  - ovf = (a_msb != b_msb) && (diff[WIDTH-1] != a_msb). BIN is treated as part of B for this check.
  - All three outputs hold stable until out_valid&&out_ready, then go to IDLE.
  - No accept occurs in the same cycle as the drain (in_ready=0 in DONE), so the minimum issue interval is NSTEP+2 cycles.
- Backpressure: with out_ready low, DONE holds indefinitely; in_valid is ignored and a/b/bin changes have no effect.
- Output retention: diff/bout/ovf keep their last values after the drain until the next DONE. Consumers qualify them with out_valid.
- Reset mid-operation: in-flight operation is aborted, no out_valid pulse is produced, and all outputs return to reset values.
- Inputs are don't-care outside the accept cycle.

Decomposition:
- Shared package:
  - state enum {IDLE, RUN, DONE}, encoded 2'b00, 2'b01, 2'b10.
  - Counter width function clog2(NSTEP), minimum 1.
- Sub-module fs_bit, combinational one-bit full subtractor:
  - D = A^B^Ci.
  - Co = (~A&B) | (~(A^B)&Ci).
  - Instantiated BPC times in a borrow chain through a generate loop.

Test Plan:
- WIDTH=8, BPC=1, a=0x05, b=0x03, bin=0 -> diff=0x02, bout=0, ovf=0; out_valid rises exactly 8 cycles after the accept edge.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1, ovf=0. a=0x10, b=0x0F, bin=1 -> diff=0x00, bout=0, ovf=0.
- a=0x80, b=0x01 -> diff=0x7F, bout=0, ovf=1. a=0x7F, b=0xFF, bin=0 -> diff=0x80, bout=1, ovf=1.
- Backpressure: out_ready held low 5 cycles in DONE while in_valid=1 with changing a/b -> outputs stable, in_ready=0, no second accept. The drain returns to IDLE and in_ready=1 the next cycle.
- Reset asserted on the 4th RUN cycle -> out_valid never asserts; diff=0, bout=0, ovf=0, in_ready=1 after release. A fresh 0x05-0x03 then yields 0x02.
- WIDTH=8, BPC=4 -> latency 2 cycles; random 1000 operands with random bin and out_ready checked against a reference model of a-b-bin, including bout and ovf.
